// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-2 stream demultiplexer and its per-port FIFOs.
package demux_pkg;
  localparam logic SEL_A          = 1'b1;
  localparam logic SEL_B          = 1'b0;
  localparam int   DATA_W_DEFAULT = 32;
  localparam int   CNT_W          = 16;
endpackage

// File: rtl/stream_fifo2.sv
// Two-entry FIFO; r_mem0 always holds the oldest beat so o_data needs no read mux.
// Full refuses push even with a same-cycle pop: no pass-through path.
module stream_fifo2
  import demux_pkg::*;
#(
  parameter int WIDTH = DATA_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_data
);

  logic [1:0]       r_occ;
  logic [WIDTH-1:0] r_mem0;
  logic [WIDTH-1:0] r_mem1;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && (r_occ != 2'd2);
  assign w_pop   = i_pop && (r_occ != 2'd0);
  assign o_full  = (r_occ == 2'd2);
  assign o_empty = (r_occ == 2'd0);
  assign o_data  = r_mem0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ  <= 2'd0;
      r_mem0 <= '0;
      r_mem1 <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_mem0 <= i_data;
          else               r_mem1 <= i_data;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_mem0 <= r_mem1;
          r_occ  <= r_occ - 2'd1;
        end
        // Both only possible at occupancy 1: the new beat replaces the departing head.
        2'b11:   r_mem0 <= i_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/demux_1x2_stream.sv
// Routes each accepted beat to port A (in_sel=1) or B (in_sel=0) through a 2-deep FIFO,
// one cycle latency; in_ready reflects only the selected port's registered occupancy.
module demux_1x2_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = DATA_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             in_ready,
  output logic             a_valid,
  output logic [WIDTH-1:0] a_data,
  input  logic             a_ready,
  output logic             b_valid,
  output logic [WIDTH-1:0] b_data,
  input  logic             b_ready,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             w_a_full;
  logic             w_a_empty;
  logic             w_b_full;
  logic             w_b_empty;
  logic             w_push_a;
  logic             w_push_b;
  logic             w_pop_a;
  logic             w_pop_b;
  logic [CNT_W-1:0] r_a_count;
  logic [CNT_W-1:0] r_b_count;

  assign in_ready = (in_sel == SEL_A) ? !w_a_full : !w_b_full;
  assign w_push_a = in_valid && in_ready && (in_sel == SEL_A);
  assign w_push_b = in_valid && in_ready && (in_sel == SEL_B);
  assign a_valid  = !w_a_empty;
  assign b_valid  = !w_b_empty;
  assign w_pop_a  = a_valid && a_ready;
  assign w_pop_b  = b_valid && b_ready;
  assign a_count  = r_a_count;
  assign b_count  = r_b_count;

  stream_fifo2 #(.WIDTH(WIDTH)) u_fifo_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push_a),
    .i_data  (in_data),
    .i_pop   (w_pop_a),
    .o_full  (w_a_full),
    .o_empty (w_a_empty),
    .o_data  (a_data)
  );

  stream_fifo2 #(.WIDTH(WIDTH)) u_fifo_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push_b),
    .i_data  (in_data),
    .i_pop   (w_pop_b),
    .o_full  (w_b_full),
    .o_empty (w_b_empty),
    .o_data  (b_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_count <= '0;
      r_b_count <= '0;
    end else begin
      if (w_pop_a) r_a_count <= r_a_count + CNT_ONE;
      if (w_pop_b) r_b_count <= r_b_count + CNT_ONE;
    end
  end

endmodule
